// File: rtl/soc_system_pio_master_pkg.sv
// rtl/soc_system_pio_master_pkg.sv - shared types and constants for the PIO initiator
package soc_system_pio_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RDW,
    ST_POLL_GAP
  } state_e;

  // Word offsets of the PIO slave registers
  localparam int unsigned PIO_DATA = 0;
  localparam int unsigned PIO_SET  = 4;
  localparam int unsigned PIO_CLR  = 5;

  localparam int unsigned READ_LATENCY_MIN = 1;
  localparam int unsigned READ_LATENCY_MAX = 4;

  function automatic int unsigned clamp_latency(input int unsigned lat);
    if (lat < READ_LATENCY_MIN) return READ_LATENCY_MIN;
    if (lat > READ_LATENCY_MAX) return READ_LATENCY_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/soc_system_pio_master_rdpipe.sv
// rtl/soc_system_pio_master_rdpipe.sv - delays the accepted-read pulse to the readdata capture strobe
module soc_system_pio_master_rdpipe #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  output logic strobe
);

  logic [DEPTH-1:0] pipe_q;
  logic [DEPTH-1:0] pipe_d;

  always_comb begin
    pipe_d    = pipe_q << 1;
    pipe_d[0] = start;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign strobe = pipe_q[DEPTH-1];

endmodule

// File: rtl/soc_system_pio_master.sv
// rtl/soc_system_pio_master.sv - Avalon-MM initiator running one PIO write/read per command
// Defining AVM_POLL_EN adds masked poll reads spaced by POLL_GAP with a POLL_MAX timeout.
module soc_system_pio_master
  import soc_system_pio_master_pkg::*;
#(
  parameter int unsigned ADDR_W       = 3,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned POLL_GAP     = 4,
  parameter int unsigned POLL_MAX     = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic              cmd_poll,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [DATA_W-1:0] cmd_match,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_read,
  output logic              avm_write_n,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest
);

  localparam int unsigned RL = clamp_latency(READ_LATENCY);

  state_e            state_q, state_d;
  logic              live_q, live_d;
  logic [ADDR_W-1:0] avm_address_q, avm_address_d;
  logic              avm_chipselect_q, avm_chipselect_d;
  logic              avm_read_q, avm_read_d;
  logic              avm_write_n_q, avm_write_n_d;
  logic [DATA_W-1:0] avm_writedata_q, avm_writedata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              cmd_accept;
  logic              rd_start;
  logic              rd_strobe;

`ifdef AVM_POLL_EN
  localparam int unsigned CNT_W    = $clog2(POLL_MAX + 1);
  localparam int unsigned GAP_W    = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
  localparam int unsigned GAP_LAST = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;

  logic              rsp_timeout_q, rsp_timeout_d;
  logic              poll_q, poll_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [DATA_W-1:0] match_q, match_d;
  logic [CNT_W-1:0]  poll_cnt_q, poll_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0]  poll_cnt_inc;
  logic              poll_hit;

  assign poll_cnt_inc = (poll_cnt_q == CNT_W'(POLL_MAX)) ? poll_cnt_q : poll_cnt_q + 1'b1;
  assign poll_hit     = ((avm_readdata & mask_q) == (match_q & mask_q));
  assign rsp_timeout  = rsp_timeout_q;
`else
  logic unused_poll_inputs;
  assign unused_poll_inputs = ^{cmd_poll, cmd_match};
  assign rsp_timeout        = 1'b0;
`endif

  assign cmd_ready  = live_q && (state_q == ST_IDLE);
  assign cmd_accept = cmd_valid && cmd_ready;
  assign rd_start   = avm_read_q && !avm_waitrequest;

  soc_system_pio_master_rdpipe #(
    .DEPTH(RL)
  ) u_rdpipe (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (rd_start),
    .strobe (rd_strobe)
  );

  always_comb begin
    state_d          = state_q;
    live_d           = 1'b1;
    avm_address_d    = avm_address_q;
    avm_chipselect_d = avm_chipselect_q;
    avm_read_d       = avm_read_q;
    avm_write_n_d    = avm_write_n_q;
    avm_writedata_d  = avm_writedata_q;
    rsp_valid_d      = 1'b0;
    rsp_rdata_d      = rsp_rdata_q;
`ifdef AVM_POLL_EN
    rsp_timeout_d    = 1'b0;
    poll_d           = poll_q;
    mask_d           = mask_q;
    match_d          = match_q;
    poll_cnt_d       = poll_cnt_q;
    gap_cnt_d        = gap_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_accept) begin
          avm_address_d    = cmd_address;
          avm_chipselect_d = 1'b1;
          if (cmd_write) begin
            avm_write_n_d   = 1'b0;
            avm_writedata_d = cmd_wdata;
            state_d         = ST_WR;
          end else begin
            avm_read_d = 1'b1;
            state_d    = ST_RD;
          end
`ifdef AVM_POLL_EN
          poll_d     = cmd_poll && !cmd_write;
          mask_d     = cmd_wdata;
          match_d    = cmd_match;
          poll_cnt_d = '0;
`endif
        end
      end
      ST_WR: begin
        if (!avm_waitrequest) begin
          avm_chipselect_d = 1'b0;
          avm_write_n_d    = 1'b1;
          rsp_valid_d      = 1'b1;
          rsp_rdata_d      = '0;
          state_d          = ST_IDLE;
        end
      end
      ST_RD: begin
        if (!avm_waitrequest) begin
          avm_chipselect_d = 1'b0;
          avm_read_d       = 1'b0;
          state_d          = ST_RDW;
        end
      end
      ST_RDW: begin
        if (rd_strobe) begin
          rsp_rdata_d = avm_readdata;
`ifdef AVM_POLL_EN
          // Poll reads loop through the gap state until a match or POLL_MAX reads
          if (poll_q) begin
            poll_cnt_d = poll_cnt_inc;
            if (poll_hit) begin
              rsp_valid_d = 1'b1;
              state_d     = ST_IDLE;
            end else if (poll_cnt_inc == CNT_W'(POLL_MAX)) begin
              rsp_valid_d   = 1'b1;
              rsp_timeout_d = 1'b1;
              state_d       = ST_IDLE;
            end else begin
              gap_cnt_d = '0;
              state_d   = ST_POLL_GAP;
            end
          end else begin
            rsp_valid_d = 1'b1;
            state_d     = ST_IDLE;
          end
`else
          rsp_valid_d = 1'b1;
          state_d     = ST_IDLE;
`endif
        end
      end
`ifdef AVM_POLL_EN
      ST_POLL_GAP: begin
        if (gap_cnt_q >= GAP_W'(GAP_LAST)) begin
          avm_chipselect_d = 1'b1;
          avm_read_d       = 1'b1;
          state_d          = ST_RD;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_IDLE;
      live_q           <= 1'b0;
      avm_address_q    <= '0;
      avm_chipselect_q <= 1'b0;
      avm_read_q       <= 1'b0;
      avm_write_n_q    <= 1'b1;
      avm_writedata_q  <= '0;
      rsp_valid_q      <= 1'b0;
      rsp_rdata_q      <= '0;
    end else begin
      state_q          <= state_d;
      live_q           <= live_d;
      avm_address_q    <= avm_address_d;
      avm_chipselect_q <= avm_chipselect_d;
      avm_read_q       <= avm_read_d;
      avm_write_n_q    <= avm_write_n_d;
      avm_writedata_q  <= avm_writedata_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_rdata_q      <= rsp_rdata_d;
    end
  end

`ifdef AVM_POLL_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_timeout_q <= 1'b0;
      poll_q        <= 1'b0;
      mask_q        <= '0;
      match_q       <= '0;
      poll_cnt_q    <= '0;
      gap_cnt_q     <= '0;
    end else begin
      rsp_timeout_q <= rsp_timeout_d;
      poll_q        <= poll_d;
      mask_q        <= mask_d;
      match_q       <= match_d;
      poll_cnt_q    <= poll_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
    end
  end
`endif

  assign avm_address    = avm_address_q;
  assign avm_chipselect = avm_chipselect_q;
  assign avm_read       = avm_read_q;
  assign avm_write_n    = avm_write_n_q;
  assign avm_writedata  = avm_writedata_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;

endmodule
